craps_controller: RTL
=====================

// Module: craps_controller
// PURPOSE
//  Game-control FSM downstream of the dice datapath. It consumes the registered 4-bit dice sum,
//  drives the datapath roll clock-enable for a fixed burst and applies craps rules
//  (come-out roll, then point phase). It outputs the point-store strobe, the held point value
//  and the win/lose status to the board LEDs and displays.
// PARAMETERS
//  ROLL_CYCLES  8  cycles roll is held high per throw; must be >= PIPE_DEPTH (elaborate-time error if not)
//  PIPE_DEPTH   3  datapath clock-enabled pipeline depth (LFSR -> Num1To6 -> Adder) before sum is valid
// PORTS
//  clock     in   1  system clock; all state updates on rising edge
//  reset     in   1  asynchronous, active-high; clears all state and outputs
//  roll_req  in   1  player throw request (synchronised level); rising edge starts a throw
//  sum       in   4  dice1+dice2 from datapath; frozen while roll is low
//  roll      out  1  clock enable to datapath (LFSRs, dice, display, adder)
//  sp        out  1  one-cycle strobe: point established this cycle
//  point     out  4  current point (4,5,6,8,9,10); 0 when no point
//  win       out  1  level, game won; held until next game starts
//  lose      out  1  level, game lost; held until next game starts
//  busy      out  1  high in ROLL/SETTLE/EVAL
//  err       out  1  one-cycle strobe: sampled sum outside 2..12
//  wins      out  8  games won (SCORE_COUNT_EN only, else 0)
//  losses    out  8  games lost (SCORE_COUNT_EN only, else 0)
// BEHAVIOUR
//  - Reset (async): state=IDLE; roll, sp, win, lose, busy, err=0; point=0; wins, losses=0; req edge reg=0.
//  - Edge detect: req_rise = roll_req & ~roll_req_q. roll_req_q is registered every cycle.
//  - States: IDLE, ROLL, SETTLE, EVAL, POINT_WAIT, WIN, LOSE. All outputs are registered.
//  - IDLE/POINT_WAIT/WIN/LOSE + req_rise -> ROLL. From WIN/LOSE: clear win, lose and point
//    in the same edge, and set phase=COMEOUT.
//  - ROLL: roll=1 for exactly ROLL_CYCLES cycles (down-counter), then -> SETTLE with roll=0.
//  - SETTLE: 1 cycle; lets the final adder output register. -> EVAL.
//  - EVAL (sum sampled this cycle) -> next state on the following edge:
//    COMEOUT: 7,11 -> WIN (win=1); 2,3,12 -> LOSE (lose=1);
//             4,5,6,8,9,10 -> point<=sum, sp=1 for one cycle, phase=POINT, -> POINT_WAIT.
//    POINT:   sum==point -> WIN; sum==7 -> LOSE; any other legal sum -> POINT_WAIT, point unchanged.
//    sum<2 or sum>12: err=1 for one cycle; no decision; return to IDLE (COMEOUT) or POINT_WAIT (POINT).
//  - req_rise during ROLL/SETTLE/EVAL is ignored and not queued.
//  - busy = (state in ROLL, SETTLE, EVAL). Latency from req_rise to win/lose/sp = ROLL_CYCLES+3 cycles.
//  - Reset mid-throw: roll drops asynchronously and the in-flight result is discarded.
//  - win and lose are never both 1. sp never coincides with win or lose.
// CONFIGURATION
//  SCORE_COUNT_EN defined:
//    - wins increments on entry to WIN; losses increments on entry to LOSE.
//    - Both are 8-bit saturating counters (hold at 255) and are cleared only by reset.
//  SCORE_COUNT_EN undefined:
//    - wins and losses are tied to 8'd0; no counter logic is built. The port list is unchanged.
// TESTING
//  1. reset high mid-ROLL -> roll=0 immediately; state IDLE; all outputs 0.
//  2. COMEOUT, sum=7 at EVAL -> win=1 at cycle ROLL_CYCLES+3 after req_rise; sp=0; point=0.
//  3. COMEOUT, sum=3 -> lose=1. Next req_rise -> lose clears on that edge and roll=1 for 8 cycles.
//  4. COMEOUT sum=6 -> sp pulses once, point=6. Then throw sum=8 -> POINT_WAIT with point=6.
//     Then throw sum=6 -> win=1.
//  5. Point=9, throw sum=7 -> lose=1. A req_rise during ROLL does not extend roll beyond 8 cycles.
//  6. sum=0 at EVAL in COMEOUT -> err pulses once and state returns to IDLE.
//     With SCORE_COUNT_EN: 256 wins -> wins=255 (saturated).

Source files
------------

// File: rtl/craps_controller.sv
// Craps game-control FSM: drives the dice roll enable burst, applies come-out/point rules.
// Optional build macro SCORE_COUNT_EN adds saturating win/loss counters.
module craps_controller #(
  parameter int ROLL_CYCLES = 8,
  parameter int PIPE_DEPTH  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       roll_req,
  input  logic [3:0] sum,
  output logic       roll,
  output logic       sp,
  output logic [3:0] point,
  output logic       win,
  output logic       lose,
  output logic       busy,
  output logic       err,
  output logic [7:0] wins,
  output logic [7:0] losses
);

  localparam int CNT_W = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;

  if (ROLL_CYCLES < PIPE_DEPTH) begin : g_param_check
    $error("ROLL_CYCLES must be >= PIPE_DEPTH");
  end

  typedef enum logic [2:0] {IDLE, ROLL, SETTLE, EVAL, POINT_WAIT, WIN, LOSE} state_t;
  typedef enum logic {PH_COMEOUT, PH_POINT} phase_t;

  state_t           state, state_n;
  phase_t           phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             roll_req_q;
  logic             req_rise;
  logic             roll_n, sp_n, win_n, lose_n, err_n, busy_n;
  logic [3:0]       point_n;

  function automatic logic is_legal(input logic [3:0] s);
    return (s >= 4'd2) && (s <= 4'd12);
  endfunction

  assign req_rise = roll_req & ~roll_req_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= PH_COMEOUT;
      cnt        <= '0;
      roll_req_q <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      cnt        <= cnt_n;
      roll_req_q <= roll_req;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    roll_n  = 1'b0;
    sp_n    = 1'b0;
    err_n   = 1'b0;
    win_n   = win;
    lose_n  = lose;
    point_n = point;
    case (state)
      IDLE, POINT_WAIT: begin
        if (req_rise) begin
          state_n = ROLL;
          roll_n  = 1'b1;
          cnt_n   = CNT_W'(ROLL_CYCLES - 1);
        end
      end
      WIN, LOSE: begin
        // A new game starts here: forget the previous result and point.
        if (req_rise) begin
          state_n = ROLL;
          roll_n  = 1'b1;
          cnt_n   = CNT_W'(ROLL_CYCLES - 1);
          win_n   = 1'b0;
          lose_n  = 1'b0;
          point_n = 4'd0;
          phase_n = PH_COMEOUT;
        end
      end
      ROLL: begin
        if (cnt == '0) begin
          state_n = SETTLE;
        end else begin
          cnt_n  = cnt - 1'b1;
          roll_n = 1'b1;
        end
      end
      SETTLE: state_n = EVAL;
      EVAL: begin
        if (!is_legal(sum)) begin
          err_n   = 1'b1;
          state_n = (phase == PH_POINT) ? POINT_WAIT : IDLE;
        end else if (phase == PH_COMEOUT) begin
          case (sum)
            4'd7, 4'd11: begin
              state_n = WIN;
              win_n   = 1'b1;
            end
            4'd2, 4'd3, 4'd12: begin
              state_n = LOSE;
              lose_n  = 1'b1;
            end
            default: begin
              state_n = POINT_WAIT;
              point_n = sum;
              sp_n    = 1'b1;
              phase_n = PH_POINT;
            end
          endcase
        end else if (sum == point) begin
          state_n = WIN;
          win_n   = 1'b1;
        end else if (sum == 4'd7) begin
          state_n = LOSE;
          lose_n  = 1'b1;
        end else begin
          state_n = POINT_WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == ROLL) || (state_n == SETTLE) || (state_n == EVAL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      roll  <= 1'b0;
      sp    <= 1'b0;
      win   <= 1'b0;
      lose  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      point <= 4'd0;
    end else begin
      roll  <= roll_n;
      sp    <= sp_n;
      win   <= win_n;
      lose  <= lose_n;
      busy  <= busy_n;
      err   <= err_n;
      point <= point_n;
    end
  end

`ifdef SCORE_COUNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wins   <= 8'd0;
      losses <= 8'd0;
    end else begin
      if (state_n == WIN && state != WIN)   wins   <= sat_inc(wins);
      if (state_n == LOSE && state != LOSE) losses <= sat_inc(losses);
    end
  end
`else
  assign wins   = 8'd0;
  assign losses = 8'd0;
`endif

endmodule
